// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS control sequencer with shared memory port
//
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, one state per clock.
// Instruction fetch and lw/sw data share one memory port through a req/ready
// handshake guarded by a wait-cycle timeout.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   op, funct           IR[31:26] / IR[5:0], sampled in DECODE
//   mem_ready           memory completed the requested access this cycle
//   mem_req, mem_write  memory request / store strobe
//   i_or_d              memory address select: 0 = PC, 1 = ALUOut
//   ir_write, pc_write  IR load / unconditional PC load
//   pc_src              00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   branch_eq/ne        PC load qualified by ALU zero = 1 / 0
//   alu_src_a/b, alu_op ALU operand selects and operation
//   reg_write, reg_dst  register file write strobe and destination select
//   mem_to_reg          write-back data select: 00 ALUOut, 01 MDR, 10 PC
//   fault               sticky illegal-opcode / memory-timeout flag
//   state               current state encoding
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       branch_eq,
    output logic       branch_ne,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_FAULT    = 4'd14
    } state_t;

    localparam logic [TO_W-1:0] TO_VAL  = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_t          state_q, state_d;
    logic [5:0]      op_q, op_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            fault_q, fault_d;

    // Ungated strobes; reset masks them below so an in-flight access aborts at once.
    logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, branch_eq_c, branch_ne_c;
    logic timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == TO_VAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        branch_eq_c = 1'b0;
        branch_ne_c = 1'b0;
        i_or_d      = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 3'b000;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b100;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b100;
                op_d      = op;
                case (op)
                    6'h00:                      state_d = (funct == 6'h08) ? S_JR : S_R_EXEC;
                    6'h23, 6'h2b:               state_d = S_MEM_ADDR;
                    6'h04, 6'h05:               state_d = S_BRANCH;
                    6'h08, 6'h0d, 6'h0c, 6'h0f: state_d = S_I_EXEC;
                    6'h02:                      state_d = S_JUMP;
                    6'h03:                      state_d = S_JAL;
                    default:                    state_d = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b100;
                state_d   = (op_q == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready)        state_d = S_MEM_WB;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_MEM_WB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 2'b01;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                i_or_d      = 1'b1;
                if (mem_ready)        state_d = S_FETCH;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b111;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst     = 2'b01;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_op      = 3'b001;
                pc_src      = 2'b01;
                branch_eq_c = (op_q == 6'h04);
                branch_ne_c = (op_q == 6'h05);
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_src     = 2'b10;
                state_d    = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    6'h0d:   alu_op = 3'b101;
                    6'h0c:   alu_op = 3'b110;
                    6'h0f:   alu_op = 3'b000;
                    default: alu_op = 3'b100;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // PC was already advanced in FETCH, so PC is the link value.
                pc_write_c  = 1'b1;
                pc_src      = 2'b10;
                reg_write_c = 1'b1;
                reg_dst     = 2'b10;
                mem_to_reg  = 2'b10;
                state_d     = S_FETCH;
            end
            S_JR: begin
                pc_write_c = 1'b1;
                pc_src     = 2'b11;
                state_d    = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Counts consecutive unanswered request cycles; any other cycle clears it.
    always_comb begin
        wait_d = '0;
        if (mem_req_c && !mem_ready) begin
            wait_d = (wait_q == TO_MAX) ? wait_q : wait_q + TO_ONE;
        end
    end

    assign fault_d = fault_q | (state_d == S_FAULT);

    assign mem_req   = mem_req_c   & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign pc_write  = pc_write_c  & ~reset;
    assign reg_write = reg_write_c & ~reset;
    assign branch_eq = branch_eq_c & ~reset;
    assign branch_ne = branch_ne_c & ~reset;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       branch_eq, branch_ne, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       fault;
    logic [3:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [31:0] vec;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] op_lat = 6'h00;

    multicycle_control_fsm #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected control outputs for a given state, from the state output table.
    function automatic logic [31:0] model(input logic [3:0] st, input logic [5:0] opl,
                                          input logic rdy, input logic rst);
        logic mr, mw, iod, irw, pcw, beq, bne, a, rw, flt;
        logic [1:0] pcs, b, rd, m2r;
        logic [2:0] alu;
        {mr, mw, iod, irw, pcw, beq, bne, a, rw, flt} = '0;
        {pcs, b, rd, m2r} = '0;
        alu = 3'b000;
        case (st)
            4'd0:  begin mr = 1; b = 2'b01; alu = 3'b100; if (rdy) begin irw = 1; pcw = 1; end end
            4'd1:  begin b = 2'b11; alu = 3'b100; end
            4'd2:  begin a = 1; b = 2'b10; alu = 3'b100; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 2'b01; end
            4'd5:  begin mr = 1; mw = 1; iod = 1; end
            4'd6:  begin a = 1; alu = 3'b111; end
            4'd7:  begin rw = 1; rd = 2'b01; end
            4'd8:  begin a = 1; alu = 3'b001; pcs = 2'b01; beq = (opl == 6'h04); bne = (opl == 6'h05); end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd10: begin
                a = 1; b = 2'b10;
                alu = (opl == 6'h08) ? 3'b100 : (opl == 6'h0d) ? 3'b101 : (opl == 6'h0c) ? 3'b110 : 3'b000;
            end
            4'd11: rw = 1;
            4'd12: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
            4'd13: begin pcw = 1; pcs = 2'b11; end
            4'd14: flt = 1;
            default: ;
        endcase
        if (rst) {mr, mw, irw, pcw, rw, beq, bne} = '0;
        return {11'b0, mr, mw, iod, irw, pcw, pcs, beq, bne, a, b, alu, rw, rd, m2r, flt};
    endfunction

    // One clock: drive inputs just after the edge, push what this cycle must show.
    task automatic cyc(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic rdy, input logic [3:0] es, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; op = o; funct = f; mem_ready = rdy;
        if (es == 4'd1) op_lat = o;
        e.tag = tag;
        e.st  = es;
        e.vec = model(es, op_lat, rdy, rst);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".state"}, {28'b0, state}, {28'b0, e.st});
            check({e.tag, ".ctl"},
                  {11'b0, mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src, branch_eq, branch_ne,
                   alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, fault}, e.vec);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] iops [4];
        iops[0] = 6'h08; iops[1] = 6'h0d; iops[2] = 6'h0c; iops[3] = 6'h0f;

        cyc(1, 6'h00, 6'h20, 1, 0, "rst0");
        cyc(1, 6'h00, 6'h20, 1, 0, "rst1");
        // R-type add: 4 cycles
        cyc(0, 6'h00, 6'h20, 1, 0, "r.fetch");
        cyc(0, 6'h00, 6'h20, 1, 1, "r.dec");
        cyc(0, 6'h00, 6'h20, 1, 6, "r.exec");
        cyc(0, 6'h00, 6'h20, 1, 7, "r.wb");
        // lw with 3 wait cycles; op changed after DECODE must not matter
        cyc(0, 6'h23, 6'h00, 1, 0, "lw.fetch");
        cyc(0, 6'h23, 6'h00, 1, 1, "lw.dec");
        cyc(0, 6'h2b, 6'h00, 1, 2, "lw.addr");
        for (int i = 0; i < 3; i++) cyc(0, 6'h2b, 6'h00, 0, 3, "lw.wait");
        cyc(0, 6'h2b, 6'h00, 1, 3, "lw.rd");
        cyc(0, 6'h2b, 6'h00, 1, 4, "lw.wb");
        // sw with one wait cycle
        cyc(0, 6'h2b, 6'h00, 1, 0, "sw.fetch");
        cyc(0, 6'h2b, 6'h00, 1, 1, "sw.dec");
        cyc(0, 6'h2b, 6'h00, 1, 2, "sw.addr");
        cyc(0, 6'h2b, 6'h00, 0, 5, "sw.wait");
        cyc(0, 6'h2b, 6'h00, 1, 5, "sw.wr");
        // beq / bne / j / jal / jr
        cyc(0, 6'h04, 6'h00, 1, 0, "beq.fetch"); cyc(0, 6'h04, 6'h00, 1, 1, "beq.dec"); cyc(0, 6'h04, 6'h00, 1, 8, "beq.br");
        cyc(0, 6'h05, 6'h00, 1, 0, "bne.fetch"); cyc(0, 6'h05, 6'h00, 1, 1, "bne.dec"); cyc(0, 6'h05, 6'h00, 1, 8, "bne.br");
        cyc(0, 6'h02, 6'h00, 1, 0, "j.fetch");   cyc(0, 6'h02, 6'h00, 1, 1, "j.dec");   cyc(0, 6'h02, 6'h00, 1, 9, "j.jump");
        cyc(0, 6'h03, 6'h00, 1, 0, "jal.fetch"); cyc(0, 6'h03, 6'h00, 1, 1, "jal.dec"); cyc(0, 6'h03, 6'h00, 1, 12, "jal.jal");
        cyc(0, 6'h00, 6'h08, 1, 0, "jr.fetch");  cyc(0, 6'h00, 6'h08, 1, 1, "jr.dec");  cyc(0, 6'h00, 6'h08, 1, 13, "jr.jr");
        // I-type: addi, ori, andi, lui
        foreach (iops[k]) begin
            cyc(0, iops[k], 6'h00, 1, 0, "i.fetch");
            cyc(0, iops[k], 6'h00, 1, 1, "i.dec");
            cyc(0, iops[k], 6'h00, 1, 10, "i.exec");
            cyc(0, iops[k], 6'h00, 1, 11, "i.wb");
        end
        // illegal opcode: sticky FAULT
        cyc(0, 6'h3f, 6'h00, 1, 0, "ill.fetch");
        cyc(0, 6'h3f, 6'h00, 1, 1, "ill.dec");
        for (int i = 0; i < 3; i++) cyc(0, 6'h00, 6'h20, 1, 14, "ill.fault");
        // fetch timeout: 16 unanswered cycles (counter 0..15) then FAULT
        cyc(1, 6'h00, 6'h20, 0, 0, "to.rst");
        for (int i = 0; i < 16; i++) cyc(0, 6'h00, 6'h20, 0, 0, "to.wait");
        for (int i = 0; i < 3; i++) cyc(0, 6'h00, 6'h20, 1, 14, "to.fault");
        // ready on the last allowed cycle wins over the timeout
        cyc(1, 6'h00, 6'h20, 0, 0, "rw.rst");
        for (int i = 0; i < 15; i++) cyc(0, 6'h00, 6'h20, 0, 0, "rw.wait");
        cyc(0, 6'h00, 6'h20, 1, 0, "rw.ready");
        cyc(0, 6'h00, 6'h20, 1, 1, "rw.dec");
        cyc(0, 6'h00, 6'h20, 1, 6, "rw.exec");
        cyc(0, 6'h00, 6'h20, 1, 7, "rw.wb");
        // reset mid MEM_WR drops strobes without a clock edge
        cyc(0, 6'h2b, 6'h00, 1, 0, "ar.fetch");
        cyc(0, 6'h2b, 6'h00, 1, 1, "ar.dec");
        cyc(0, 6'h2b, 6'h00, 1, 2, "ar.addr");
        cyc(0, 6'h2b, 6'h00, 0, 5, "ar.wr");
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("ar.mem_req",   {31'b0, mem_req},   32'd0);
        check("ar.mem_write", {31'b0, mem_write}, 32'd0);
        check("ar.state",     {28'b0, state},     32'd0);
        cyc(1, 6'h2b, 6'h00, 0, 0, "ar.hold");
        cyc(0, 6'h2b, 6'h00, 0, 0, "ar.post");

        @(negedge clk);
        #1;
        check("sb.empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
